// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   MEM-stage data memory controller. It performs byte, half and word loads
//   and stores on a single-ported 32-bit word memory, with a configurable
//   number of wait states. While an access is in flight it holds the
//   upstream pipeline stages with `stall`.
//
//   Optional feature macro: DMEM_MISALIGN_TRAP_EN
//     defined   : misaligned half/word accesses are flagged on `misalign`.
//                 The store is suppressed and RD is left unchanged, but the
//                 access still takes its full latency.
//     undefined : the low address bits are forced to alignment, the access
//                 proceeds, and `misalign` is always 0.
//
// Parameters
//   DEPTH        memory size in 32-bit words (power of two)
//   WAIT_CYCLES  extra access cycles per request (0..15)
//
// Ports
//   clk          clock; all state updates on posedge
//   rst          synchronous active-high reset
//   MemRead      load request
//   MemWrite     store request (wins when MemRead is also high)
//   ALUout       byte address
//   WD           store data, right-aligned
//   Size         00 byte, 01 half, 10/11 word
//   LoadUnsigned 1 = zero-extend sub-word loads, 0 = sign-extend
//   RD           registered load data, valid in the DONE cycle
//   stall        combinational pipeline freeze
//   misalign     registered misalignment flag of the last committed access

module data_mem_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUout,
  input  logic [31:0] WD,
  input  logic [1:0]  Size,
  input  logic        LoadUnsigned,
  output logic [31:0] RD,
  output logic        stall,
  output logic        misalign
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BA_W   = ADDR_W + 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  // Request captured when it is accepted in IDLE.
  logic [BA_W-1:0]   addr_q;
  logic [31:0]       wd_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              wr_q;

  logic [31:0]       mem [DEPTH];

  // Address bits above the memory size are ignored, so addresses wrap.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^ALUout[31:BA_W];

  logic              req_c;
  logic [BA_W-1:0]   addr_c;
  logic [31:0]       wd_c;
  logic [1:0]        size_c;
  logic              uns_c;
  logic              wr_c;
  logic              commit_c;

  assign req_c = MemRead | MemWrite;

  // Commit from IDLE uses the live request (zero wait states); from ACCESS
  // it uses the latched copy so late input changes have no effect.
  always_comb begin
    addr_c = addr_q;
    wd_c   = wd_q;
    size_c = size_q;
    uns_c  = uns_q;
    wr_c   = wr_q;
    if (state == IDLE) begin
      addr_c = ALUout[BA_W-1:0];
      wd_c   = WD;
      size_c = Size;
      uns_c  = LoadUnsigned;
      wr_c   = MemWrite;
    end
  end

  assign commit_c = !rst &&
                    (((state == IDLE) && req_c && (WAIT_CYCLES == 0)) ||
                     ((state == ACCESS) && (cnt == '0)));

  // stall covers the accepting IDLE cycle and every ACCESS cycle.
  assign stall = !rst && (((state == IDLE) && req_c) || (state == ACCESS));

  logic              is_half_c;
  logic              is_word_c;
  logic              mis_c;
  logic [1:0]        lane_c;
  logic [ADDR_W-1:0] idx_c;

  assign is_half_c = (size_c == 2'b01);
  assign is_word_c = size_c[1];
  assign idx_c     = addr_c[BA_W-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_c  = (is_half_c && addr_c[0]) || (is_word_c && (addr_c[1:0] != 2'b00));
  assign lane_c = addr_c[1:0];
`else
  assign mis_c  = 1'b0;
  assign lane_c = is_word_c ? 2'b00 :
                  is_half_c ? {addr_c[1], 1'b0} :
                              addr_c[1:0];
`endif

  logic [31:0] word_c;
  logic [31:0] wdata_c;
  logic [3:0]  be_c;
  logic [31:0] merged_c;
  logic [31:0] shifted_c;
  logic [31:0] load_c;

  assign word_c = mem[idx_c];

  // Replicate store data across lanes and enable only the addressed ones.
  always_comb begin
    wdata_c = {4{wd_c[7:0]}};
    be_c    = 4'b0001 << lane_c;
    if (is_word_c) begin
      wdata_c = wd_c;
      be_c    = 4'b1111;
    end else if (is_half_c) begin
      wdata_c = {2{wd_c[15:0]}};
      be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    merged_c = word_c;
    for (int b = 0; b < 4; b++) begin
      if (be_c[b]) merged_c[8*b +: 8] = wdata_c[8*b +: 8];
    end
  end

  // Bring the addressed lane down to bit 0, then extend.
  assign shifted_c = word_c >> {lane_c, 3'b000};

  always_comb begin
    load_c = word_c;
    if (!is_word_c) begin
      if (is_half_c) begin
        load_c = uns_c ? {16'h0000, shifted_c[15:0]}
                       : {{16{shifted_c[15]}}, shifted_c[15:0]};
      end else begin
        load_c = uns_c ? {24'h000000, shifted_c[7:0]}
                       : {{24{shifted_c[7]}}, shifted_c[7:0]};
      end
    end
  end

  // Memory array: not reset; a store lands on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (commit_c && wr_c && !mis_c) begin
      mem[idx_c] <= merged_c;
    end
  end

  // Access sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wr_q     <= 1'b0;
      RD       <= '0;
      misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_c) begin
            addr_q <= ALUout[BA_W-1:0];
            wd_q   <= WD;
            size_q <= Size;
            uns_q  <= LoadUnsigned;
            wr_q   <= MemWrite;
            if (WAIT_CYCLES == 0) begin
              state <= DONE;
            end else begin
              state <= ACCESS;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit_c) begin
        misalign <= mis_c;
        if (!wr_c && !mis_c) begin
          RD <= load_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
//   Randomized and directed stimulus for data_mem_ctrl, checked against a
//   behavioural model: a word array, the last load value and the misalign
//   flag, all updated from the access rules with plain arithmetic.

module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 2;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ALUout;
  logic [31:0] WD;
  logic [1:0]  Size;
  logic        LoadUnsigned;
  logic [31:0] RD;
  logic        stall;
  logic        misalign;

  data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk),
    .rst(rst),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .ALUout(ALUout),
    .WD(WD),
    .Size(Size),
    .LoadUnsigned(LoadUnsigned),
    .RD(RD),
    .stall(stall),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] rd_m;
  logic        mis_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one access, applied to the model state.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic u);
    int          idx;
    int          nbytes;
    int          off;
    logic        bad_align;
    logic [31:0] v;
    idx    = int'((a / 4) % DEPTH);
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off    = int'(a % 4);
    bad_align = (off % nbytes) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_m = bad_align;
    if (bad_align) return;
`else
    off   = off - (off % nbytes);
`endif
    if (w) begin
      for (int k = 0; k < nbytes; k++) mem_m[idx][8*(off+k) +: 8] = d[8*k +: 8];
    end else begin
      v = 0;
      for (int k = 0; k < nbytes; k++) v[8*k +: 8] = mem_m[idx][8*(off+k) +: 8];
      if (!u && nbytes < 4 && v[8*nbytes-1]) v = v - (32'd1 << (8*nbytes)); // two's complement sign extend
      rd_m = v;
    end
  endtask

  // Issue one request, measure the stall length and check the DONE cycle.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u);
    int n;
    model_access(w, a, d, sz, u);
    @(negedge clk);
    MemRead = r; MemWrite = w; ALUout = a; WD = d; Size = sz; LoadUnsigned = u;
    #1;
    n = 0;
    while (stall && n < 64) begin
      @(negedge clk); #1;
      n++;
      if (stall) begin
        ALUout       = $urandom;
        WD           = $urandom;
        Size         = 2'($urandom_range(0, 3));
        LoadUnsigned = 1'($urandom_range(0, 1));
      end
    end
    check("latency", 32'(n), 32'(1 + WAITC));
    check("rd_done", RD, rd_m);
    check("misalign", 32'(misalign), 32'(mis_m));
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk); #1;
    check("rd_hold", RD, rd_m);
    check("idle_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ALUout = 32'h10; WD = 0; Size = 2'b10;
    LoadUnsigned = 1'b0;
    rd_m = 0; mis_m = 1'b0;

    // Reset with a pending request
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rd", RD, 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    @(negedge clk);
    rst = 1'b0; MemRead = 1'b0;

    // Preload every word so later loads have known data
    for (int i = 0; i < int'(DEPTH); i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0);

    // Word store/load and sub-word extension
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    check("lw_10", RD, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0);
    check("lb_13", RD, 32'hFFFFFFDE);
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1);
    check("lbu_13", RD, 32'h000000DE);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0);
    check("lh_10", RD, 32'hFFFFBEEF);
    do_req(1'b1, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1);
    check("lhu_12", RD, 32'h0000DEAD);
    do_req(1'b0, 1'b1, 32'h11, 32'h55, 2'b00, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    check("sb_lw_10", RD, 32'hDEAD55EF);

    // Address wrap and simultaneous read/write
    do_req(1'b0, 1'b1, 32'h400, 32'h12345678, 2'b10, 1'b0);
    do_req(1'b1, 1'b0, 32'h000, 32'h0, 2'b10, 1'b0);
    check("wrap_lw_0", RD, 32'h12345678);
    do_req(1'b1, 1'b1, 32'h04, 32'hCAFEF00D, 2'b10, 1'b0);
    check("rw_rd_keep", RD, 32'h12345678);
    do_req(1'b1, 1'b0, 32'h04, 32'h0, 2'b10, 1'b0);
    check("rw_stored", RD, 32'hCAFEF00D);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic w;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      do_req(r, w, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset during ACCESS of a store
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; ALUout = 32'h20; WD = 32'hFFFFFFFF; Size = 2'b10;
    #1;
    check("abort_stall_req", 32'(stall), 32'd1);
    @(negedge clk); #1;
    check("abort_stall_acc", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_stall_rst", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; MemWrite = 1'b0;
    #1;
    rd_m = 0; mis_m = 1'b0;
    check("abort_rd", RD, 32'd0);
    check("abort_mis", 32'(misalign), 32'd0);
    check("abort_idle_stall", 32'(stall), 32'd0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    check("abort_mem", RD, mem_m[8]);

    // Misaligned word load
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
    do_req(1'b1, 1'b0, 32'h21, 32'h0, 2'b10, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_rd_keep", RD, mem_m[12]);
`else
    check("mis_flag", 32'(misalign), 32'd0);
    check("mis_rd_aligned", RD, mem_m[8]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
